muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared multiplier/divider resource and the HI/LO registers of the multi-cycle CPU.
//  Accepts one MULT/DIV request from the control unit and pulses the matching start.
//  Waits for that unit's ready, then drives the HI/LO source select and write enables for one cycle.
//  Detects divide-by-zero before the divider is started; holds busy so the control unit stalls.
// PARAMETERS
//  CNT_W    6   width of the per-operation cycle counter
//  TIMEOUT  40  cycles in WAIT before abort (used only with MULDIV_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  req_valid    in   1   control unit requests an operation
//  req_op       in   1   0=MULT, 1=DIV
//  op_b         in   32  divisor/multiplier operand (B register output)
//  req_ready    out  1   high only in IDLE; a request is accepted when req_valid & req_ready
//  busy         out  1   high in every state except IDLE
//  mult_start   out  1   one-cycle start pulse to the multiplier
//  div_start    out  1   one-cycle start pulse to the divider
//  mult_ready   in   1   multiplier result valid
//  div_ready    in   1   divider result valid
//  hilo_src     out  1   HI/LO input select: 0=multiplier, 1=divider; holds last op
//  hi_wr        out  1   HI write enable, one cycle
//  lo_wr        out  1   LO write enable, one cycle
//  done         out  1   one-cycle pulse when HI/LO are written
//  exc_div0     out  1   one-cycle pulse on DIV with op_b==0; no start, no HI/LO write
//  last_lat     out  CNT_W  cycles from start to ready of the last completed op; saturates
//  timeout_err  out  1   one-cycle abort pulse; present only with MULDIV_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except req_ready=1. Reset mid-operation aborts silently, with no done and no write.
//  States: IDLE, START, WAIT, WRITE, EXC. Transitions are registered.
//  IDLE: on accept with DIV and op_b==0, go to EXC. On any other accept, latch req_op into hilo_src and go to START.
//  START: drive mult_start or div_start (per hilo_src) high for exactly 1 cycle; clear the counter; go to WAIT.
//  WAIT: sample only the selected unit's ready. The other unit's ready is ignored.
//   A ready seen during START is stale and is ignored.
//   The counter increments each WAIT cycle and saturates at 2^CNT_W-1.
//   When ready is seen, capture the counter into last_lat and go to WRITE.
//  WRITE: hi_wr=lo_wr=done=1 for 1 cycle; return to IDLE.
//  EXC: exc_div0=1 for 1 cycle; return to IDLE. HI/LO and last_lat are unchanged.
//  Latency from accept to done = 3 + N cycles, where N is the number of WAIT cycles up to and including the ready cycle.
//  req_valid while busy is ignored and is not queued; the control unit re-asserts it.
//  op_b is sampled only in the accept cycle.
//  Back-to-back: a new request is accepted in the IDLE cycle after WRITE/EXC.
// CONFIGURATION
//  MULDIV_TIMEOUT_EN defined: when the counter reaches TIMEOUT in WAIT, pulse timeout_err for 1 cycle and go to IDLE.
//   No HI/LO write occurs; last_lat is loaded with TIMEOUT.
//  MULDIV_TIMEOUT_EN undefined: WAIT persists until ready; the timeout_err port is absent.
// STRUCTURE
//  Package muldiv_pkg: state encodings (3-bit), op codes OP_MULT=0 / OP_DIV=1, HILO_SRC_* constants.
//  Sub-module muldiv_cycle_cnt: saturating counter with clear/enable and a terminal-count compare at TIMEOUT.
//  The FSM stays in this module.
// TESTING
//  MULT, op_b=7, mult_ready 33 cycles after start -> mult_start 1 pulse; done + hi_wr + lo_wr at accept+36; hilo_src=0; last_lat=33.
//  DIV, op_b=0 -> exc_div0 at accept+1; div_start never rises; hi_wr stays 0; busy for 1 cycle.
//  DIV, op_b=5, div_ready held high during START and mult_ready pulsing during WAIT -> both ignored; done only after div_ready in WAIT.
//  req_valid held high through a MULT -> only one accept; second accept in the cycle after done.
//  Reset asserted in WAIT -> all outputs 0 and req_ready=1 immediately; no done after deassert.
//  MULDIV_TIMEOUT_EN, TIMEOUT=40, ready never asserted -> timeout_err at WAIT cycle 40; IDLE next cycle; no HI/LO write.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer.
//   state_t           FSM state encoding (3-bit)
//   OP_MULT / OP_DIV  request opcodes carried on req_op
//   HILO_SRC_*        HI/LO input-select values
//   is_div0()         divide-by-zero detect on an incoming request
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT       = 1'b0;
  localparam logic OP_DIV        = 1'b1;
  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

  function automatic logic is_div0(input logic op, input logic [31:0] b);
    return (op == OP_DIV) && (b == 32'd0);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: control-unit / mul-div unit / HI-LO bundle around the sequencer.
//   master modport: control unit + arithmetic units (drive req_*, op_b, *_ready)
//   slave  modport: the sequencer (drives req_ready, busy, starts, HI/LO controls, status)
//   timeout_err exists only when MULDIV_TIMEOUT_EN is defined.
interface muldiv_sequencer_if #(
  parameter int CNT_W = 6
);
  import muldiv_pkg::*;

  logic             req_valid;
  logic             req_op;
  logic [31:0]      op_b;
  logic             req_ready;
  logic             busy;
  logic             mult_start;
  logic             div_start;
  logic             mult_ready;
  logic             div_ready;
  logic             hilo_src;
  logic             hi_wr;
  logic             lo_wr;
  logic             done;
  logic             exc_div0;
  logic [CNT_W-1:0] last_lat;
`ifdef MULDIV_TIMEOUT_EN
  logic             timeout_err;
`endif

  modport slave (
    input  req_valid, req_op, op_b, mult_ready, div_ready,
    output req_ready, busy, mult_start, div_start, hilo_src,
           hi_wr, lo_wr, done, exc_div0, last_lat
`ifdef MULDIV_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output req_valid, req_op, op_b, mult_ready, div_ready,
    input  req_ready, busy, mult_start, div_start, hilo_src,
           hi_wr, lo_wr, done, exc_div0, last_lat
`ifdef MULDIV_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/muldiv_cycle_cnt.sv
// muldiv_cycle_cnt: saturating per-operation cycle counter.
//   clk, reset  clock / async active-high reset
//   clr         synchronous clear (wins over en)
//   en          count one cycle; holds at all-ones
//   cnt         current count
//   tc          high in the enabled cycle whose increment brings cnt to TIMEOUT
import muldiv_pkg::*;

module muldiv_cycle_cnt #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TC_PRE  = CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (en && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
  end

  assign tc = en && (cnt == TC_PRE);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multiplier/divider and the HI/LO writes.
//   clk, reset  clock / async active-high reset
//   bus         muldiv_sequencer_if.slave: request handshake, unit starts/readies,
//               HI/LO select + write enables, done / exc_div0 / last_lat status
// Optional: MULDIV_TIMEOUT_EN adds a TIMEOUT-cycle abort in WAIT and the
// timeout_err pulse; without it WAIT lasts until the selected unit is ready.
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  state_t           state;
  logic             req_ready_r, busy_r, mult_start_r, div_start_r;
  logic             hilo_src_r, hi_wr_r, lo_wr_r, done_r, exc_div0_r;
  logic [CNT_W-1:0] last_lat_r;
  logic             ready_q;
  logic             sel_ready;
  logic [CNT_W-1:0] cnt;
  logic             tc;
`ifdef MULDIV_TIMEOUT_EN
  logic             timeout_err_r;
`endif

  muldiv_cycle_cnt #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_START),
    .en    (state == S_WAIT),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Only the unit that was started is listened to.
  assign sel_ready = (hilo_src_r == HILO_SRC_DIV) ? bus.div_ready : bus.mult_ready;

  // ready is registered and sampled only while in WAIT, so a level left over
  // from START never reaches the FSM. The FSM acts on it one cycle later,
  // which is also when cnt equals the number of WAIT cycles through ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      mult_start_r <= 1'b0;
      div_start_r  <= 1'b0;
      hilo_src_r   <= HILO_SRC_MULT;
      hi_wr_r      <= 1'b0;
      lo_wr_r      <= 1'b0;
      done_r       <= 1'b0;
      exc_div0_r   <= 1'b0;
      last_lat_r   <= '0;
      ready_q      <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
    end else begin
      mult_start_r <= 1'b0;
      div_start_r  <= 1'b0;
      hi_wr_r      <= 1'b0;
      lo_wr_r      <= 1'b0;
      done_r       <= 1'b0;
      exc_div0_r   <= 1'b0;
      ready_q      <= (state == S_WAIT) && sel_ready;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (is_div0(bus.req_op, bus.op_b)) begin
              state      <= S_EXC;
              exc_div0_r <= 1'b1;
            end else begin
              state      <= S_START;
              hilo_src_r <= bus.req_op;
              // Start pulse is registered here so it is high for the START cycle.
              if (bus.req_op == OP_DIV) div_start_r  <= 1'b1;
              else                      mult_start_r <= 1'b1;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (ready_q) begin
            state      <= S_WRITE;
            last_lat_r <= cnt;
            hi_wr_r    <= 1'b1;
            lo_wr_r    <= 1'b1;
            done_r     <= 1'b1;
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (tc) begin
            state         <= S_IDLE;
            req_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            last_lat_r    <= CNT_W'(TIMEOUT);
            timeout_err_r <= 1'b1;
          end
`endif
        end
        S_WRITE, S_EXC: begin
          state       <= S_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_r;
`else
  logic unused_tc;
  assign unused_tc = tc;
`endif

  assign bus.req_ready  = req_ready_r;
  assign bus.busy       = busy_r;
  assign bus.mult_start = mult_start_r;
  assign bus.div_start  = div_start_r;
  assign bus.hilo_src   = hilo_src_r;
  assign bus.hi_wr      = hi_wr_r;
  assign bus.lo_wr      = lo_wr_r;
  assign bus.done       = done_r;
  assign bus.exc_div0   = exc_div0_r;
  assign bus.last_lat   = last_lat_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scoreboard bench for muldiv_sequencer.
// Driver pushes the expected completion event (kind, cycle, hilo_src, last_lat);
// a negedge monitor pops and compares whenever done / exc_div0 / timeout_err fires.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.CNT_W(CNT_W)) bus ();
  muldiv_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int   kind;   // 0 done, 1 exc_div0, 2 timeout
    int   cyc;
    logic src;
    int   lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks  = 0;
  int   passes  = 0;
  int   cyc     = 0;
  int   mstarts = 0;
  int   dstarts = 0;
  int   accepts = 0;
  logic m_src   = 1'b0;
  int   m_lat   = 0;
  logic to_ev;

`ifdef MULDIV_TIMEOUT_EN
  assign to_ev = bus.timeout_err;
`else
  assign to_ev = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int sat(input int n);
    return (n > 63) ? 63 : n;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mult_start) mstarts++;
      if (bus.div_start)  dstarts++;
      if (bus.req_valid && bus.req_ready) accepts++;
      if ((bus.hi_wr || bus.lo_wr) && !bus.done) check("stray_hilo_write", 1, 0);
      if (bus.done || bus.exc_div0 || to_ev) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {bus.done, bus.exc_div0, to_ev}, 0);
        end else begin
          e_mon = sb.pop_front();
          check("event_kind", bus.done ? 0 : (bus.exc_div0 ? 1 : 2), e_mon.kind);
          check("event_cycle", cyc, e_mon.cyc);
          check("hilo_src", bus.hilo_src, e_mon.src);
          check("last_lat", bus.last_lat, e_mon.lat);
          if (e_mon.kind == 0) check("hi_lo_wr", {bus.hi_wr, bus.lo_wr}, 2'b11);
          else                 check("no_hi_lo_wr", {bus.hi_wr, bus.lo_wr}, 2'b00);
        end
      end
    end
  end

  // Caller is #1 after a posedge; returns #1 after the accept edge (START cycle).
  task automatic issue(input logic op, input logic [31:0] b, input logic hold, output int a);
    bit got = 0;
    a = -1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.op_b      = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1;
        a = cyc;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Drive the chosen unit's ready for one cycle in WAIT cycle n (1-based).
  task automatic pulse_ready(input logic div, input int n);
    repeat (n) @(posedge clk);
    #1;
    if (div) bus.div_ready = 1'b1; else bus.mult_ready = 1'b1;
    @(posedge clk); #1;
    bus.div_ready  = 1'b0;
    bus.mult_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic op, input logic [31:0] b, input int n);
    int a, ms0, ds0;
    ms0 = mstarts; ds0 = dstarts;
    issue(op, b, 1'b0, a);
    sb.push_back('{0, a + 3 + n, op, sat(n)});
    m_src = op; m_lat = sat(n);
    pulse_ready(op, n);
    drain();
    check("mult_start_pulses", mstarts - ms0, (op == OP_MULT) ? 1 : 0);
    check("div_start_pulses",  dstarts - ds0, (op == OP_DIV)  ? 1 : 0);
  endtask

  initial begin
    int a, a2, ds0, acc0;
    bus.req_valid = 0; bus.req_op = 0; bus.op_b = 0;
    bus.mult_ready = 0; bus.div_ready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_starts", {bus.mult_start, bus.div_start}, 0);
    check("rst_writes", {bus.hi_wr, bus.lo_wr, bus.done, bus.exc_div0}, 0);
    check("rst_src_lat", {bus.hilo_src, bus.last_lat}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MULT, 33 WAIT cycles -> done at accept+36, last_lat 33
    run_op(OP_MULT, 32'd7, 33);

    // DIV by zero: exc at accept+1, busy one cycle, no start
    ds0 = dstarts;
    issue(OP_DIV, 32'd0, 1'b0, a);
    sb.push_back('{1, a + 1, m_src, m_lat});
    @(negedge clk);
    check("div0_busy", bus.busy, 1);
    @(negedge clk);
    check("div0_idle", {bus.busy, bus.req_ready}, 2'b01);
    drain();
    check("div0_no_start", dstarts - ds0, 0);

    // DIV b=5: stale div_ready in START, mult_ready noise in WAIT, op_b changed after accept
    ds0 = dstarts;
    issue(OP_DIV, 32'd5, 1'b0, a);
    sb.push_back('{0, a + 7, OP_DIV, 4});
    m_src = OP_DIV; m_lat = 4;
    bus.div_ready = 1'b1; bus.op_b = 32'd0;
    @(posedge clk); #1; bus.div_ready = 1'b0; bus.mult_ready = 1'b1;
    @(posedge clk); #1; bus.mult_ready = 1'b0;
    @(posedge clk); #1; bus.mult_ready = 1'b1;
    @(posedge clk); #1; bus.mult_ready = 1'b0; bus.div_ready = 1'b1;
    @(posedge clk); #1; bus.div_ready = 1'b0;
    drain();
    check("stale_div_start", dstarts - ds0, 1);

    // req_valid held through a MULT: second accept right after done
    acc0 = accepts;
    issue(OP_MULT, 32'd3, 1'b1, a);
    sb.push_back('{0, a + 5, OP_MULT, 2});
    pulse_ready(OP_MULT, 2);
    issue(OP_MULT, 32'd3, 1'b0, a2);
    check("held_second_accept", a2, a + 6);
    sb.push_back('{0, a2 + 4, OP_MULT, 1});
    m_src = OP_MULT; m_lat = 1;
    pulse_ready(OP_MULT, 1);
    drain();
    check("held_accept_count", accepts - acc0, 2);

    // Saturation and minimum latency
    run_op(OP_MULT, 32'd1, 70);
    run_op(OP_DIV, 32'd2, 1);

    // Reset in WAIT: silent abort
    issue(OP_MULT, 32'd4, 1'b0, a);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_outs", {bus.mult_start, bus.div_start, bus.hi_wr, bus.lo_wr, bus.done,
                          bus.exc_div0, bus.hilo_src, bus.last_lat}, 0);
    m_src = 0; m_lat = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mult_ready = 1'b1;
    @(posedge clk); #1;
    bus.mult_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_still_idle", {bus.busy, bus.req_ready}, 2'b01);

    // Recovery after reset
    run_op(OP_DIV, 32'd9, 3);

`ifdef MULDIV_TIMEOUT_EN
    issue(OP_MULT, 32'd1, 1'b0, a);
    sb.push_back('{2, a + 42, OP_MULT, TIMEOUT});
    m_src = OP_MULT; m_lat = TIMEOUT;
    drain();
    check("timeout_idle", {bus.busy, bus.req_ready}, 2'b01);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
